// File: rtl/dmem_port_arbiter.sv
// Purpose: shares one single-port fixed-latency data memory between IF (read) and MEM (read/write).
// Latency: dm_en one cycle after grant; write done +2, read done +2+READ_LATENCY cycles from request.
// Backpressure: requesters hold req until done; *_stall = req & ~done, MEM wins, done cycle masks its owner.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_done,
  output logic                  if_stall,
  input  logic                  mem_req,
  input  logic                  mem_wr,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_done,
  output logic                  mem_stall,
  output logic                  dm_en,
  output logic                  dm_we,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  output logic [DATA_WIDTH-1:0] dm_wdata,
  input  logic [DATA_WIDTH-1:0] dm_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam int unsigned CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_t        state;
  logic          owner_mem;  // 1: access in flight belongs to MEM, 0: to IF
  logic [CW-1:0] lat_cnt;
  logic          mem_elig;
  logic          if_elig;

  // A requester completing this cycle still has req high; mask it so it is not served twice.
  assign mem_elig  = mem_req & ~mem_done;
  assign if_elig   = if_req & ~if_done;

  // Stalls follow the handshake directly so the hazard unit sees them in the done cycle.
  assign if_stall  = if_req & ~if_done;
  assign mem_stall = mem_req & ~mem_done;

  // Arbitration FSM: grant in IDLE, one strobe cycle in ACCESS, count out read latency in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_mem <= 1'b0;
      lat_cnt   <= '0;
      dm_en     <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_elig) begin
            owner_mem <= 1'b1;
            dm_en     <= 1'b1;
            dm_we     <= mem_wr;
            dm_addr   <= mem_addr;
            dm_wdata  <= mem_wdata;
            state     <= ACCESS;
          end else if (if_elig) begin
            owner_mem <= 1'b0;
            dm_en     <= 1'b1;
            dm_we     <= 1'b0;
            dm_addr   <= if_addr;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          dm_en <= 1'b0;
          dm_we <= 1'b0;
          if (dm_we) begin
            // Only MEM can write, so a write always completes to MEM without touching rdata.
            mem_done <= 1'b1;
            state    <= IDLE;
          end else begin
            lat_cnt <= CW'(READ_LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            if (owner_mem) begin
              mem_rdata <= dm_rdata;
              mem_done  <= 1'b1;
            end else begin
              if_rdata <= dm_rdata;
              if_done  <= 1'b1;
            end
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a READ_LATENCY=1 instance driven from a per-cycle
// vector table plus reset sequences, and a READ_LATENCY=3 instance with a mid-access reset.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance with READ_LATENCY = 1 ----------------
  logic        rst_n;
  logic        if_req, mem_req, mem_wr;
  logic [31:0] if_addr, mem_addr, mem_wdata, dm_rdata;
  logic [31:0] if_rdata, mem_rdata, dm_addr, dm_wdata;
  logic        if_done, if_stall, mem_done, mem_stall, dm_en, dm_we;

  dmem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
    .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  // ---------------- instance with READ_LATENCY = 3 ----------------
  logic        rst3_n;
  logic        if_req_3, mem_req_3, mem_wr_3;
  logic [31:0] if_addr_3, mem_addr_3, mem_wdata_3, dm_rdata_3;
  logic [31:0] if_rdata_3, mem_rdata_3, dm_addr_3, dm_wdata_3;
  logic        if_done_3, if_stall_3, mem_done_3, mem_stall_3, dm_en_3, dm_we_3;

  dmem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst3_n),
    .if_req(if_req_3), .if_addr(if_addr_3), .if_rdata(if_rdata_3), .if_done(if_done_3),
    .if_stall(if_stall_3),
    .mem_req(mem_req_3), .mem_wr(mem_wr_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3), .mem_done(mem_done_3), .mem_stall(mem_stall_3),
    .dm_en(dm_en_3), .dm_we(dm_we_3), .dm_addr(dm_addr_3), .dm_wdata(dm_wdata_3),
    .dm_rdata(dm_rdata_3)
  );

  // ---------------- memory models ----------------
  function automatic logic [31:0] base_rd(input logic [31:0] a);
    case (a)
      32'h40:  return 32'hDEADBEEF;
      32'h44:  return 32'h11112222;
      32'h48:  return 32'h33334444;
      32'h100: return 32'hCAFEF00D;
      default: return a ^ 32'h5A5A0000;
    endcase
  endfunction

  logic        wr_vld = 1'b0;
  logic [31:0] wr_a   = 32'h0;
  logic [31:0] wr_d   = 32'h0;
  logic [31:0] rd1    = 32'h0;

  // Registered read, data valid one cycle after the strobe edge; garbage otherwise.
  always @(posedge clk) begin
    if (dm_en && dm_we) begin
      wr_vld <= 1'b1;
      wr_a   <= dm_addr;
      wr_d   <= dm_wdata;
    end
    if (dm_en && !dm_we)
      rd1 <= (wr_vld && dm_addr == wr_a) ? wr_d : base_rd(dm_addr);
    else
      rd1 <= 32'hBADBAD01;
  end
  assign dm_rdata = rd1;

  logic [31:0] p0 = 32'h0, p1 = 32'h0, p2 = 32'h0;

  // Three-stage read pipe: data valid exactly three cycles after the strobe edge.
  always @(posedge clk) begin
    p0 <= (dm_en_3 && !dm_we_3) ? base_rd(dm_addr_3) : 32'hBADBAD03;
    p1 <= p0;
    p2 <= p1;
  end
  assign dm_rdata_3 = p2;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // flags = {dm_en, dm_we, if_done, mem_done, if_stall, mem_stall}
  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        mr;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] md;
    logic [5:0]  e_flags;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_ird;
    logic [31:0] e_mrd;
  } vec_t;

  localparam int NV = 31;
  vec_t vt[NV];

  function automatic vec_t v(input logic ir, input logic [31:0] ia, input logic mr, input logic mw,
                             input logic [31:0] ma, input logic [31:0] md, input logic [5:0] fl,
                             input logic [31:0] ea, input logic [31:0] ew,
                             input logic [31:0] eir, input logic [31:0] emr);
    vec_t r;
    r.ir = ir; r.ia = ia; r.mr = mr; r.mw = mw; r.ma = ma; r.md = md;
    r.e_flags = fl; r.e_addr = ea; r.e_wdata = ew; r.e_ird = eir; r.e_mrd = emr;
    return r;
  endfunction

  task automatic run_l3_read(input logic [31:0] a, input logic [31:0] exp_rd, input string tag);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if_req_3  = (k <= 5);
      if_addr_3 = a;
      #1;
      check($sformatf("%s c%0d en/done/stall", tag, k), {61'd0, dm_en_3, if_done_3, if_stall_3},
            {61'd0, (k == 1), (k == 5), (k < 5)});
      if (k == 1) check($sformatf("%s dm_addr", tag), {32'd0, dm_addr_3}, {32'd0, a});
      if (k >= 5) check($sformatf("%s c%0d if_rdata", tag, k), {32'd0, if_rdata_3}, {32'd0, exp_rd});
    end
  endtask

  initial begin
    logic [5:0] fl;
    // Stimulus table for the L=1 instance, one row per cycle.
    //          ir ia       mr mw ma       md        flags      addr     wdata    if_rdata     mem_rdata
    vt[0]  = v(0, 32'h0,   1, 0, 32'h40, 32'h0,    6'b000001, 32'h0,   32'h0,    32'h0,       32'h0);
    vt[1]  = v(0, 32'h0,   1, 0, 32'h40, 32'h0,    6'b100001, 32'h40,  32'h0,    32'h0,       32'h0);
    vt[2]  = v(0, 32'h0,   1, 0, 32'h40, 32'h0,    6'b000001, 32'h0,   32'h0,    32'h0,       32'h0);
    vt[3]  = v(0, 32'h0,   1, 0, 32'h40, 32'h0,    6'b000100, 32'h0,   32'h0,    32'h0,       32'hDEADBEEF);
    vt[4]  = v(0, 32'h0,   0, 0, 32'h0,  32'h0,    6'b000000, 32'h0,   32'h0,    32'h0,       32'hDEADBEEF);
    vt[5]  = v(0, 32'h0,   1, 1, 32'h80, 32'h1234, 6'b000001, 32'h0,   32'h0,    32'h0,       32'hDEADBEEF);
    vt[6]  = v(0, 32'h0,   1, 0, 32'h0,  32'h0,    6'b110001, 32'h80,  32'h1234, 32'h0,       32'hDEADBEEF);
    vt[7]  = v(0, 32'h0,   1, 0, 32'h0,  32'h0,    6'b000100, 32'h0,   32'h0,    32'h0,       32'hDEADBEEF);
    vt[8]  = v(0, 32'h0,   0, 0, 32'h0,  32'h0,    6'b000000, 32'h0,   32'h0,    32'h0,       32'hDEADBEEF);
    vt[9]  = v(1, 32'h80,  0, 0, 32'h0,  32'h0,    6'b000010, 32'h0,   32'h0,    32'h0,       32'hDEADBEEF);
    vt[10] = v(1, 32'h80,  0, 0, 32'h0,  32'h0,    6'b100010, 32'h80,  32'h0,    32'h0,       32'hDEADBEEF);
    vt[11] = v(1, 32'h80,  0, 0, 32'h0,  32'h0,    6'b000010, 32'h0,   32'h0,    32'h0,       32'hDEADBEEF);
    vt[12] = v(1, 32'h80,  0, 0, 32'h0,  32'h0,    6'b001000, 32'h0,   32'h0,    32'h1234,    32'hDEADBEEF);
    vt[13] = v(0, 32'h0,   0, 0, 32'h0,  32'h0,    6'b000000, 32'h0,   32'h0,    32'h1234,    32'hDEADBEEF);
    vt[14] = v(1, 32'h100, 1, 0, 32'h44, 32'h0,    6'b000011, 32'h0,   32'h0,    32'h1234,    32'hDEADBEEF);
    vt[15] = v(1, 32'h100, 1, 0, 32'h44, 32'h0,    6'b100011, 32'h44,  32'h0,    32'h1234,    32'hDEADBEEF);
    vt[16] = v(1, 32'h100, 1, 0, 32'h44, 32'h0,    6'b000011, 32'h0,   32'h0,    32'h1234,    32'hDEADBEEF);
    vt[17] = v(1, 32'h100, 1, 0, 32'h44, 32'h0,    6'b000110, 32'h0,   32'h0,    32'h1234,    32'h11112222);
    vt[18] = v(1, 32'h100, 1, 0, 32'h44, 32'h0,    6'b100011, 32'h100, 32'h0,    32'h1234,    32'h11112222);
    vt[19] = v(1, 32'h100, 1, 0, 32'h44, 32'h0,    6'b000011, 32'h0,   32'h0,    32'h1234,    32'h11112222);
    vt[20] = v(1, 32'h100, 1, 0, 32'h48, 32'h0,    6'b001001, 32'h0,   32'h0,    32'hCAFEF00D, 32'h11112222);
    vt[21] = v(1, 32'h100, 1, 0, 32'h48, 32'h0,    6'b100011, 32'h48,  32'h0,    32'hCAFEF00D, 32'h11112222);
    vt[22] = v(1, 32'h100, 1, 0, 32'h48, 32'h0,    6'b000011, 32'h0,   32'h0,    32'hCAFEF00D, 32'h11112222);
    vt[23] = v(1, 32'h100, 1, 0, 32'h48, 32'h0,    6'b000110, 32'h0,   32'h0,    32'hCAFEF00D, 32'h33334444);
    vt[24] = v(1, 32'h100, 1, 0, 32'h48, 32'h0,    6'b100011, 32'h100, 32'h0,    32'hCAFEF00D, 32'h33334444);
    vt[25] = v(1, 32'h100, 1, 0, 32'h48, 32'h0,    6'b000011, 32'h0,   32'h0,    32'hCAFEF00D, 32'h33334444);
    vt[26] = v(1, 32'h100, 1, 0, 32'h40, 32'h0,    6'b001001, 32'h0,   32'h0,    32'hCAFEF00D, 32'h33334444);
    vt[27] = v(0, 32'h0,   0, 0, 32'h0,  32'h0,    6'b100000, 32'h40,  32'h0,    32'hCAFEF00D, 32'h33334444);
    vt[28] = v(0, 32'h0,   0, 0, 32'h0,  32'h0,    6'b000000, 32'h0,   32'h0,    32'hCAFEF00D, 32'h33334444);
    vt[29] = v(0, 32'h0,   0, 0, 32'h0,  32'h0,    6'b000100, 32'h0,   32'h0,    32'hCAFEF00D, 32'hDEADBEEF);
    vt[30] = v(0, 32'h0,   0, 0, 32'h0,  32'h0,    6'b000000, 32'h0,   32'h0,    32'hCAFEF00D, 32'hDEADBEEF);

    rst_n = 1'b0; rst3_n = 1'b0;
    if_req = 0; if_addr = 0; mem_req = 0; mem_wr = 0; mem_addr = 0; mem_wdata = 0;
    if_req_3 = 0; if_addr_3 = 0; mem_req_3 = 0; mem_wr_3 = 0; mem_addr_3 = 0; mem_wdata_3 = 0;

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    #1;
    fl = {dm_en, dm_we, if_done, mem_done, if_stall, mem_stall};
    check("reset flags", {58'd0, fl}, 64'd0);
    check("reset dm_addr/wdata", {dm_addr, dm_wdata}, 64'd0);
    check("reset rdata", {if_rdata, mem_rdata}, 64'd0);
    check("reset L3 outputs", {58'd0, dm_en_3, dm_we_3, if_done_3, mem_done_3, if_stall_3, mem_stall_3}, 64'd0);

    @(negedge clk);
    rst_n = 1'b1; rst3_n = 1'b1;

    // Idle for 10 cycles with no requests: nothing may fire.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      fl = {dm_en, dm_we, if_done, mem_done, if_stall, mem_stall};
      check($sformatf("idle c%0d flags", k), {58'd0, fl}, 64'd0);
    end
    check("idle dm_addr", {32'd0, dm_addr}, 64'd0);

    // Table-driven main sequence.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if_req = vt[i].ir; if_addr = vt[i].ia;
      mem_req = vt[i].mr; mem_wr = vt[i].mw; mem_addr = vt[i].ma; mem_wdata = vt[i].md;
      #1;
      fl = {dm_en, dm_we, if_done, mem_done, if_stall, mem_stall};
      check($sformatf("row%0d flags", i), {58'd0, fl}, {58'd0, vt[i].e_flags});
      if (vt[i].e_flags[5])
        check($sformatf("row%0d dm_addr", i), {32'd0, dm_addr}, {32'd0, vt[i].e_addr});
      if (vt[i].e_flags[5] && vt[i].e_flags[4])
        check($sformatf("row%0d dm_wdata", i), {32'd0, dm_wdata}, {32'd0, vt[i].e_wdata});
      check($sformatf("row%0d rdata if/mem", i), {if_rdata, mem_rdata}, {vt[i].e_ird, vt[i].e_mrd});
    end

    // Reset asserted while an L=1 MEM read is in its strobe cycle.
    @(negedge clk);
    mem_req = 1; mem_wr = 0; mem_addr = 32'h40;
    @(negedge clk);
    #1;
    check("midrst dm_en before", {63'd0, dm_en}, 64'd1);
    rst_n = 1'b0;
    mem_req = 0;
    #1;
    check("midrst dm_en drop", {63'd0, dm_en}, 64'd0);
    check("midrst addr/rdata", {dm_addr, mem_rdata}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) rst_n = 1'b1;
      #1;
      check($sformatf("midrst c%0d en/done", k), {61'd0, dm_en, mem_done, if_done}, 64'd0);
    end

    // READ_LATENCY=3: plain IF read, then one abandoned by reset, then a fresh one.
    run_l3_read(32'h100, 32'hCAFEF00D, "L3 read");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if_req_3  = (k < 3);
      if_addr_3 = 32'h104;
      if (k == 6) rst3_n = 1'b1;
      #1;
      if (k == 1) check("L3 abort dm_en@1", {63'd0, dm_en_3}, 64'd1);
      if (k == 3) begin
        rst3_n = 1'b0;
        #1;
        check("L3 abort rdata cleared", {32'd0, if_rdata_3}, 64'd0);
      end
      if (k >= 3) check($sformatf("L3 abort c%0d en/done", k), {62'd0, dm_en_3, if_done_3}, 64'd0);
    end
    run_l3_read(32'h48, 32'h33334444, "L3 fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
